// File: rtl/iterative_denormalizer.sv
// iterative_denormalizer: multi-cycle right-shift denormalizer.
// Shifts a normalized word right by a leading-zero count, four bits per cycle
// while at least four remain, then one bit per cycle. Every bit shifted out is
// folded into a sticky flag. Valid/ready handshake; flush_i aborts in-flight work.
//
// Optional build macro DENORM_GUARD_BIT_EN: adds guard_o (the last bit shifted
// out). With it, sticky_o excludes that bit; without it, sticky_o covers all.
//
// Internally the last shifted-out bit is always tracked separately from the
// older ones, so both builds share a single datapath. Only the output
// combination differs.
module iterative_denormalizer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          valid_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] shift_i,
  input  logic                          flush_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic [DATA_WIDTH-1:0]         result_o,
  output logic                          sticky_o
`ifdef DENORM_GUARD_BIT_EN
  ,
  output logic                          guard_o
`endif
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] NIB_STEP = SW'(4);
  localparam logic [SW-1:0] BIT_STEP = SW'(1);

  // Only 24- and 32-bit operands are supported.
  generate
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 24)) begin : g_bad_width
      $error("iterative_denormalizer: DATA_WIDTH must be 24 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_NIBBLE,
    S_BIT,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [SW-1:0]           rem_reg, rem_next;
  logic                    sticky_reg, sticky_next;   // OR of all but the last bit shifted out
  logic                    guard_reg, guard_next;     // most recent bit shifted out
  logic [DATA_WIDTH-1:0]   result_reg;
  logic                    sticky_out_reg;
  logic                    guard_out_reg;
  logic                    shift_big;
  logic                    load_result;

  // A shift of DATA_WIDTH or more is only encodable when DATA_WIDTH is not a power of two.
  generate
    if (DATA_WIDTH < (1 << SW)) begin : g_big_shift
      assign shift_big = (shift_i >= SW'(DATA_WIDTH));
    end else begin : g_no_big_shift
      assign shift_big = 1'b0;
    end
  endgenerate

  // Next-state and datapath step logic; flush overrides everything.
  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    rem_next    = rem_reg;
    sticky_next = sticky_reg;
    guard_next  = guard_reg;
    case (state_reg)
      S_IDLE: begin
        if (valid_i) begin
          data_next   = operand_i;
          rem_next    = shift_i;
          sticky_next = 1'b0;
          guard_next  = 1'b0;
          if (shift_big) begin
            data_next   = '0;
            rem_next    = '0;
            sticky_next = |operand_i;
            state_next  = S_DONE;
          end else if (shift_i == '0) begin
            state_next = S_DONE;
          end else if (shift_i >= NIB_STEP) begin
            state_next = S_NIBBLE;
          end else begin
            state_next = S_BIT;
          end
        end
      end
      S_NIBBLE: begin
        // Bit [3] becomes the new guard; the previous guard and bits [2:0] retire into sticky.
        data_next   = data_reg >> 4;
        sticky_next = sticky_reg | guard_reg | (|data_reg[2:0]);
        guard_next  = data_reg[3];
        rem_next    = rem_reg - NIB_STEP;
        if (rem_next < NIB_STEP) begin
          state_next = (rem_next != '0) ? S_BIT : S_DONE;
        end
      end
      S_BIT: begin
        data_next   = data_reg >> 1;
        sticky_next = sticky_reg | guard_reg;
        guard_next  = data_reg[0];
        rem_next    = rem_reg - BIT_STEP;
        if (rem_next == '0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (flush_i) begin
      state_next  = S_IDLE;
      data_next   = '0;
      rem_next    = '0;
      sticky_next = 1'b0;
      guard_next  = 1'b0;
    end
  end

  assign load_result = (state_next == S_DONE) && (state_reg != S_DONE);

  // State and working registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= S_IDLE;
      data_reg   <= '0;
      rem_reg    <= '0;
      sticky_reg <= 1'b0;
      guard_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      rem_reg    <= rem_next;
      sticky_reg <= sticky_next;
      guard_reg  <= guard_next;
    end
  end

  // Result registers: captured on entry to DONE, held until the next result, flush or reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_reg     <= '0;
      sticky_out_reg <= 1'b0;
      guard_out_reg  <= 1'b0;
    end else if (flush_i) begin
      result_reg     <= '0;
      sticky_out_reg <= 1'b0;
      guard_out_reg  <= 1'b0;
    end else if (load_result) begin
      result_reg     <= data_next;
      sticky_out_reg <= sticky_next;
      guard_out_reg  <= guard_next;
    end
  end

  assign ready_o  = (state_reg == S_IDLE);
  assign valid_o  = (state_reg == S_DONE);
  assign result_o = result_reg;

`ifdef DENORM_GUARD_BIT_EN
  assign sticky_o = sticky_out_reg;
  assign guard_o  = guard_out_reg;
`else
  assign sticky_o = sticky_out_reg | guard_out_reg;
`endif

endmodule

// File: tb/tb_iterative_denormalizer.sv
// Scoreboard bench for iterative_denormalizer: one 32-bit and one 24-bit instance.
// Stimulus pushes hand-computed expectations; per-instance monitors pop and compare on valid_o.
module tb_iterative_denormalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // 32-bit instance
  logic        valid_a, flush_a, ready_a, vout_a, sticky_a, guard_a;
  logic [31:0] operand_a, result_a;
  logic [4:0]  shift_a;
  // 24-bit instance
  logic        valid_b, flush_b, ready_b, vout_b, sticky_b, guard_b;
  logic [23:0] operand_b, result_b;
  logic [4:0]  shift_b;

  typedef struct {
    logic [31:0] result;
    logic        sticky;
    logic        guard;
    int          lat;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iterative_denormalizer #(.DATA_WIDTH(32)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_a), .operand_i(operand_a),
    .shift_i(shift_a), .flush_i(flush_a), .ready_o(ready_a), .valid_o(vout_a),
    .result_o(result_a), .sticky_o(sticky_a)
`ifdef DENORM_GUARD_BIT_EN
    , .guard_o(guard_a)
`endif
  );

  iterative_denormalizer #(.DATA_WIDTH(24)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_b), .operand_i(operand_b),
    .shift_i(shift_b), .flush_i(flush_b), .ready_o(ready_b), .valid_o(vout_b),
    .result_o(result_b), .sticky_o(sticky_b)
`ifdef DENORM_GUARD_BIT_EN
    , .guard_o(guard_b)
`endif
  );

`ifndef DENORM_GUARD_BIT_EN
  assign guard_a = 1'b0;
  assign guard_b = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Issue one request. st_all: OR of all shifted-out bits; st_ex: excluding the last one.
  task automatic send(input int dut, input logic [31:0] op, input logic [4:0] s,
                      input logic [31:0] res, input logic st_all, input logic st_ex,
                      input logic gd, input bit push);
    int   n;
    int   si;
    int   dw;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    while (!((dut == 0) ? ready_a : ready_b) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL send_ready_timeout dut=%0d actual=busy required=ready", dut);
    end
    if (dut == 0) begin
      valid_a = 1'b1; operand_a = op; shift_a = s;
    end else begin
      valid_b = 1'b1; operand_b = op[23:0]; shift_b = s;
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    si = int'(s);
    dw = (dut == 0) ? 32 : 24;
    e.result = res;
`ifdef DENORM_GUARD_BIT_EN
    e.sticky = st_ex;
`else
    e.sticky = st_all;
`endif
    e.guard = gd;
    e.lat   = (si >= dw) ? 0 : (si / 4 + si % 4);
    e.acc   = cyc;
    if (push) begin
      if (dut == 0) qa.push_back(e);
      else          qb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (rst_n && vout_a) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_valid actual=%h required=no_output", result_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        $display("txn a result=%h sticky=%b guard=%b lat=%0d", result_a, sticky_a, guard_a, cyc - e.acc);
        chk("a_result", result_a, e.result);
        chk("a_sticky", 32'(sticky_a), 32'(e.sticky));
`ifdef DENORM_GUARD_BIT_EN
        chk("a_guard", 32'(guard_a), 32'(e.guard));
`endif
        chk("a_latency", cyc - e.acc, e.lat);
        chk("a_ready_in_done", 32'(ready_a), 32'd0);
      end
    end
  end

  // Monitor for the 24-bit instance.
  always @(negedge clk) begin
    if (rst_n && vout_b) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_valid actual=%h required=no_output", result_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        $display("txn b result=%h sticky=%b guard=%b lat=%0d", result_b, sticky_b, guard_b, cyc - e.acc);
        chk("b_result", 32'(result_b), e.result);
        chk("b_sticky", 32'(sticky_b), 32'(e.sticky));
`ifdef DENORM_GUARD_BIT_EN
        chk("b_guard", 32'(guard_b), 32'(e.guard));
`endif
        chk("b_latency", cyc - e.acc, e.lat);
        chk("b_ready_in_done", 32'(ready_b), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    valid_a = 1'b0; flush_a = 1'b0; operand_a = '0; shift_a = '0;
    valid_b = 1'b0; flush_b = 1'b0; operand_b = '0; shift_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_valid_a", 32'(vout_a), 32'd0);
    chk("rst_result_a", result_a, 32'd0);
    chk("rst_sticky_a", 32'(sticky_a), 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    chk("rst_result_b", 32'(result_b), 32'd0);
    rst_n = 1'b1;

    // Longest shift; valid_i held high while busy must be ignored.
    send(0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    valid_a = 1'b1; operand_a = 32'hDEAD_BEEF; shift_a = 5'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("a_ready_low_busy", 32'(ready_a), 32'd0);
    valid_a = 1'b0;
    wait_idle();
    chk("a_result_hold", result_a, 32'h0000_0001);

    // Nibble step with guard separation.
    send(0, 32'hF000_000F, 5'd4, 32'h0F00_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // Zero shift followed by an immediate second request.
    send(0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
    send(0, 32'h0000_0040, 5'd6, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Assorted directed vectors.
    send(0, 32'h0000_0003, 5'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    send(0, 32'h0000_0010, 5'd5, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(0, 32'h0000_0008, 5'd4, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(0, 32'hABCD_EF01, 5'd8, 32'h00AB_CDEF, 1'b1, 1'b1, 1'b0, 1'b1);
    send(0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // 24-bit instance: out-of-range shifts and boundaries.
    send(1, 32'h0000_0001, 5'd25, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(1, 32'h0000_0000, 5'd30, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1, 32'h0080_0000, 5'd23, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1, 32'h00FF_FFFF, 5'd24, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(1, 32'h00FF_FFFF, 5'd3, 32'h001F_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("b_result_hold", 32'(result_b), 32'h001F_FFFF);

    // Flush during the second NIBBLE cycle: no output, cleared result.
    send(0, 32'h1234_5678, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    chk("flush_ready", 32'(ready_a), 32'd1);
    chk("flush_result", result_a, 32'd0);
    chk("flush_sticky", 32'(sticky_a), 32'd0);
`ifdef DENORM_GUARD_BIT_EN
    chk("flush_guard", 32'(guard_a), 32'd0);
`endif
    repeat (15) @(posedge clk);
    send(0, 32'h1234_5678, 5'd13, 32'h0000_91A2, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of BIT steps.
    send(0, 32'h0000_000F, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready_a", 32'(ready_a), 32'd1);
    chk("arst_valid_a", 32'(vout_a), 32'd0);
    chk("arst_result_a", result_a, 32'd0);
    chk("arst_sticky_a", 32'(sticky_a), 32'd0);
    chk("arst_result_b", 32'(result_b), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 32'h0000_000F, 5'd3, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
